disp_scan_ctrl: RTL
===================

Name: disp_scan_ctrl

Overview:
Scan controller for the calculator's 4-digit multiplexed 7-segment display. It holds the displayed 16-bit value in a shadow register, updates it atomically at frame boundaries via a valid/ready handshake, and times per-digit dwell with an all-off gap between digits to prevent ghosting. It also applies leading-zero suppression and blink. Outputs drive the existing nibble-to-segment decoder, with blank forcing segments off, and the active-low digit enables directly.

Parameters:
DWELL_CYC, 100000, cycles each digit is driven (>=1)
GAP_CYC, 1000, all-digits-off cycles before each digit (>=1)
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
val_data  in  16  new display value, nibble k = digit k (digit 0 rightmost)
val_valid  in  1  val_data offered
val_ready  out  1  pending buffer empty, transfer on valid&&ready
lz_en  in  1  leading-zero suppression enable
blink_en  in  1  blink enable
nibble  out  4  hex digit to segment decoder
seg_blank  out  1  1 = decoder output must be forced all-off
an_n  out  4  active-low one-hot digit enable, bit k = digit k
frame_tick  out  1  one-cycle pulse at end of each frame

Behaviour:
- Clock is clk; reset is synchronous and active-low on rst_n, sampled at clk rising edge.
- All outputs registered; no combinational input-to-output path. val_ready = ~pending_v.
- Reset values: state GAP, idx 0, timer 0, shadow 0x0000, pending_v 0, blink counter 0, phase 0. Outputs: an_n 4'hF, seg_blank 1, nibble 0, val_ready 1, frame_tick 0.
- Mid-operation reset: any pending value is discarded; scanning restarts from GAP at idx 0.
- FSM GAP: an_n=F, seg_blank=1 for GAP_CYC cycles, then SHOW with the current idx.
- FSM SHOW: lasts DWELL_CYC cycles, with nibble = shadow[4*idx+3:4*idx]. If visible, an_n = ~(1<<idx) and seg_blank=0; otherwise an_n=F and seg_blank=1. Timing is identical either way. On SHOW end: GAP, idx = idx+1 mod 4.
- Frame = 4*(GAP_CYC+DWELL_CYC) cycles, scan order 0,1,2,3.
- Visible = not suppressed AND not (blink_en AND phase).
- Leading-zero suppression: when lz_en=1, digit k>=1 is suppressed iff shadow[15:4k]==0. Digit 0 is never suppressed, so 0x0000 shows "0".
- Handshake: on valid&&ready, pending<=val_data and pending_v<=1; val_ready drops the next cycle. A source holding valid while ready=0 keeps its data; it is not lost.
- Frame end (last cycle of SHOW, idx 3):
  - frame_tick=1 for exactly that cycle.
  - If pending_v: shadow<=pending, pending_v<=0. The new value is shown from the next frame's digit 0; ready returns 1 the following cycle.
  - No accept can occur in the same cycle as a commit (ready=0 then).
- Blink: frame counter increments on frame_tick; on reaching BLINK_FRAMES-1 it wraps to 0 and phase toggles. blink_en=0 holds counter and phase at 0, so enabling always starts in the visible phase.
- lz_en and blink_en are sampled live each cycle; they take effect at the next SHOW entry (visibility latched on SHOW entry).

Test Plan:
Bench parameters: DWELL_CYC=4, GAP_CYC=2, BLINK_FRAMES=2.
1. Reset/timing: release rst_n -> 2 cycles an_n=F, then an_n=E for 4 cycles with nibble 0; frame_tick first pulses at cycle 24 after release, then every 24 cycles; val_ready=1.
2. Atomic update: offer 0x1234 mid-frame -> accepted, val_ready=0 next cycle, display stays 0000 until frame_tick. Next frame shows nibbles 4,3,2,1 with an_n E,D,B,7, and val_ready returns 1 the cycle after frame_tick.
3. Leading zeros, lz_en=1:
   - 0x0050 -> digits 0,1 shown (0,5); digits 2,3 an_n=F, seg_blank=1.
   - 0x0000 -> only digit 0 shown.
   - lz_en=0 -> all four shown.
4. Blink: blink_en=1 -> frames 0-1 visible, frames 2-3 all an_n=F, repeating; drop blink_en -> visible from next SHOW.
5. Back-pressure: 0xAAAA accepted, then 0xBBBB held with valid=1 while ready=0 -> 0xBBBB accepted after the next frame_tick; display shows AAAA one frame, then BBBB.
6. Reset mid-SHOW with pending 0xCCCC -> outputs return to reset values; 0xCCCC is never displayed; display shows 0000.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan controller for a 4-digit multiplexed 7-segment display.
//
// Holds the displayed 16-bit value in a shadow register. A new value is taken
// into a one-entry pending buffer through a valid/ready handshake, and moves
// into the shadow only at a frame boundary, so a frame never mixes two values.
// Each digit gets an all-off gap (anti-ghosting) followed by a dwell period.
// Leading-zero suppression and blink decide per digit whether it is lit.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   val_data   new display value, nibble k = digit k (digit 0 rightmost)
//   val_valid  val_data offered
//   val_ready  pending buffer empty; transfer on val_valid && val_ready
//   lz_en      leading-zero suppression enable
//   blink_en   blink enable
//   nibble     hex digit to the segment decoder
//   seg_blank  1 = decoder output forced all-off
//   an_n       active-low one-hot digit enable, bit k = digit k
//   frame_tick one-cycle pulse on the last cycle of each frame
module disp_scan_ctrl #(
    parameter int unsigned DWELL_CYC    = 100000,
    parameter int unsigned GAP_CYC      = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] val_data,
    input  logic        val_valid,
    output logic        val_ready,
    input  logic        lz_en,
    input  logic        blink_en,
    output logic [3:0]  nibble,
    output logic        seg_blank,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int unsigned MaxCyc = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int unsigned TimerW = $clog2(MaxCyc + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {StGap, StShow} state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [15:0]         shadow_q, shadow_d;
    logic [15:0]         pending_q, pending_d;
    logic                pending_v_q, pending_v_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic                vis_q, vis_d;
    logic [3:0]          an_n_q, an_n_d;
    logic                seg_blank_q, seg_blank_d;
    logic [3:0]          nibble_q, nibble_d;
    logic                frame_tick_q, frame_tick_d;

    logic                frame_end;
    logic                suppressed;
    logic                show_on;

    // Leading-zero test for the digit about to be entered (idx does not change
    // on the GAP -> SHOW transition, so idx_q is the digit being entered).
    always_comb begin
        suppressed = 1'b0;
        unique case (idx_q)
            2'd0: suppressed = 1'b0;
            2'd1: suppressed = (shadow_q[15:4] == 12'h000);
            2'd2: suppressed = (shadow_q[15:8] == 8'h00);
            2'd3: suppressed = (shadow_q[15:12] == 4'h0);
            default: suppressed = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q + TimerW'(1);
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pending_v_d = pending_v_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        vis_d       = vis_q;
        frame_end   = 1'b0;

        unique case (state_q)
            StGap: begin
                if (timer_q == TimerW'(GAP_CYC - 1)) begin
                    state_d = StShow;
                    timer_d = '0;
                    // Visibility is frozen for the whole dwell.
                    vis_d   = ~(lz_en & suppressed) & ~(blink_en & phase_q);
                end
            end
            StShow: begin
                if (timer_q == TimerW'(DWELL_CYC - 1)) begin
                    state_d   = StGap;
                    timer_d   = '0;
                    idx_d     = idx_q + 2'd1;
                    frame_end = (idx_q == 2'd3);
                end
            end
            default: state_d = StGap;
        endcase

        // Accept and commit are mutually exclusive: accept needs an empty
        // buffer, commit needs a full one.
        if (val_valid && !pending_v_q) begin
            pending_d   = val_data;
            pending_v_d = 1'b1;
        end
        if (frame_end && pending_v_q) begin
            shadow_d    = pending_q;
            pending_v_d = 1'b0;
        end

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end

        // Outputs are registered from next-state values so they line up with
        // the state register rather than lagging it by a cycle.
        show_on      = (state_d == StShow) && vis_d;
        an_n_d       = show_on ? ~(4'b0001 << idx_d) : 4'hF;
        seg_blank_d  = ~show_on;
        nibble_d     = shadow_d[{idx_d, 2'b00} +: 4];
        frame_tick_d = (state_d == StShow) && (idx_d == 2'd3) &&
                       (timer_d == TimerW'(DWELL_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StGap;
            idx_q        <= 2'd0;
            timer_q      <= '0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pending_v_q  <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            vis_q        <= 1'b0;
            an_n_q       <= 4'hF;
            seg_blank_q  <= 1'b1;
            nibble_q     <= 4'h0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pending_v_q  <= pending_v_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            vis_q        <= vis_d;
            an_n_q       <= an_n_d;
            seg_blank_q  <= seg_blank_d;
            nibble_q     <= nibble_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign val_ready  = ~pending_v_q;
    assign an_n       = an_n_q;
    assign seg_blank  = seg_blank_q;
    assign nibble     = nibble_q;
    assign frame_tick = frame_tick_q;

endmodule
